// File: rtl/sfu_seq.sv
// Sequencer for one accumulation/ReLU SFU lane: psum reads, SFU controls, output writes.
// Optional SFU_SEQ_PERF_EN adds a perf_cycles busy-cycle counter port.
module sfu_seq #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              os_or_ws,
    input  logic [CNT_W-1:0]  num_acc,
    input  logic [CNT_W-1:0]  num_out,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              sfu_acc,
    output logic              sfu_relu,
    output logic              sfu_zero_in,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr
`ifdef SFU_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_RELU  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               os_q, os_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   nout_q, nout_d;
    logic [CNT_W-1:0]   o_q, o_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]  base_q, base_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               acc_q, acc_d;
    logic               relu_q, relu_d;
    logic               zero_q, zero_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
`ifdef SFU_SEQ_PERF_EN
    logic [31:0]        perf_q, perf_d;
`endif

    // Next-state, counters, and the output values for the coming cycle.
    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        n_d     = n_q;
        nout_d  = nout_q;
        o_d     = o_q;
        k_d     = k_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    os_d    = os_or_ws;
                    n_d     = (num_acc == {CNT_W{1'b0}}) ? CNT_W'(1) : num_acc;
                    nout_d  = num_out;
                    o_d     = {CNT_W{1'b0}};
                    k_d     = {CNT_W{1'b0}};
                    base_d  = {ADDR_W{1'b0}};
                    state_d = (num_out == {CNT_W{1'b0}}) ? S_DONE : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (os_q) begin
                    state_d = S_RELU;
                end else if (k_q == n_q - CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    // running base k*N_out + o, wrapping in the address width
                    k_d    = k_q + CNT_W'(1);
                    base_d = base_q + ADDR_W'(nout_q);
                end
            end
            S_DRAIN: state_d = S_RELU;
            S_RELU:  state_d = S_WRITE;
            S_WRITE: begin
                if (o_q == nout_q - CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    o_d     = o_q + CNT_W'(1);
                    k_d     = {CNT_W{1'b0}};
                    base_d  = ADDR_W'(o_q) + ADDR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rd_en_d   = (state_d == S_ISSUE);
        rd_addr_d = (state_d == S_ISSUE) ? base_d : {ADDR_W{1'b0}};
        // acc follows the read strobe by one cycle, matching read-data latency
        acc_d     = rd_en_q & ~os_q;
        relu_d    = (state_d == S_RELU);
        zero_d    = (state_d == S_RELU) & ~os_d;
        wr_en_d   = (state_d == S_WRITE);
        wr_addr_d = (state_d == S_WRITE) ? ADDR_W'(o_d) : {ADDR_W{1'b0}};
`ifdef SFU_SEQ_PERF_EN
        if (state_q == S_IDLE && start) begin
            perf_d = 32'd0;
        end else if (busy_q) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
`endif
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            os_q      <= 1'b0;
            n_q       <= {CNT_W{1'b0}};
            nout_q    <= {CNT_W{1'b0}};
            o_q       <= {CNT_W{1'b0}};
            k_q       <= {CNT_W{1'b0}};
            base_q    <= {ADDR_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            acc_q     <= 1'b0;
            relu_q    <= 1'b0;
            zero_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
`ifdef SFU_SEQ_PERF_EN
            perf_q    <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            os_q      <= os_d;
            n_q       <= n_d;
            nout_q    <= nout_d;
            o_q       <= o_d;
            k_q       <= k_d;
            base_q    <= base_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            acc_q     <= acc_d;
            relu_q    <= relu_d;
            zero_q    <= zero_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
`ifdef SFU_SEQ_PERF_EN
            perf_q    <= perf_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign sfu_acc     = acc_q;
    assign sfu_relu    = relu_q;
    assign sfu_zero_in = zero_q;
    assign out_wr_en   = wr_en_q;
    assign out_wr_addr = wr_addr_q;
`ifdef SFU_SEQ_PERF_EN
    assign perf_cycles = perf_q;
`endif

endmodule
